// File: rtl/vote_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vote_pkg
//  Description : Shared types and constants for the vote tally engine:
//                FSM state encoding, mode encodings and the legal ranges
//                of the engine parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
package vote_pkg;

    // Engine control states
    typedef enum logic [1:0] {
        ST_LOCKED = 2'd0,
        ST_ARMED  = 2'd1,
        ST_SCAN   = 2'd2,
        ST_RESULT = 2'd3
    } vote_state_e;

    // Encodings of the mode input
    localparam logic MODE_VOTE   = 1'b0;
    localparam logic MODE_RESULT = 1'b1;

    // Legal parameter ranges
    localparam int NUM_CAND_MIN    = 2;
    localparam int NUM_CAND_MAX    = 16;
    localparam int CNT_W_MIN       = 4;
    localparam int CNT_W_MAX       = 16;
    localparam int HOLD_CYCLES_MIN = 1;

endpackage : vote_pkg
`default_nettype wire

// File: rtl/vote_button_qualifier.sv
`default_nettype none
// ============================================================================
//  Module      : vote_button_qualifier
//  Description : Two-flop synchroniser followed by a hold qualifier for one
//                raw button. Emits a single one-cycle pulse once the
//                synchronised level has been high for HOLD_CYCLES
//                consecutive cycles; re-arms only after the level drops.
//  Ports       : clk       - clock
//                rst_n     - asynchronous active-low reset
//                button_in - raw asynchronous button level
//                pulse     - one-cycle qualified press pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module vote_button_qualifier
    import vote_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_in,
    output logic pulse
);

    localparam int HC_W = $clog2(HOLD_CYCLES + 1);

    generate
        if (HOLD_CYCLES < HOLD_CYCLES_MIN) begin : g_hold_check
            $error("vote_button_qualifier: HOLD_CYCLES below minimum");
        end
    endgenerate

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
    logic            fired_q, fired_d;

    // hold_cnt_q counts the high cycles already seen before the current one,
    // so the pulse fires on the HOLD_CYCLES-th consecutive high cycle.
    always_comb begin
        sync1_d    = button_in;
        sync2_d    = sync1_q;
        hold_cnt_d = hold_cnt_q;
        fired_d    = fired_q;
        pulse      = 1'b0;
        if (!sync2_q) begin
            hold_cnt_d = '0;
            fired_d    = 1'b0;
        end else if (!fired_q) begin
            if (hold_cnt_q == HC_W'(HOLD_CYCLES - 1)) begin
                pulse   = 1'b1;
                fired_d = 1'b1;
            end else begin
                hold_cnt_d = hold_cnt_q + HC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            hold_cnt_q <= '0;
            fired_q    <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            hold_cnt_q <= hold_cnt_d;
            fired_q    <= fired_d;
        end
    end

endmodule : vote_button_qualifier
`default_nettype wire

// File: rtl/vote_tally_engine.sv
`default_nettype none
// ============================================================================
//  Module      : vote_tally_engine
//  Description : Ballot-controlled vote counter. An officer arms one ballot,
//                a single qualified button press records one vote, and a
//                result mode scans all counters to find the winner and ties.
//  Ports       : clk          - clock
//                rst_n        - asynchronous active-low reset
//                mode         - 0 voting, 1 result
//                ballot_arm   - enable exactly one ballot
//                button       - raw candidate buttons
//                disp_sel     - candidate shown on sel_count
//                armed        - ballot pending
//                vote_ack     - vote recorded (1-cycle pulse)
//                vote_reject  - multi-button press (1-cycle pulse)
//                sel_count    - count of candidate disp_sel
//                total_votes  - sum of recorded increments
//                winner       - lowest index holding the maximum
//                tie          - maximum shared by two or more candidates
//                result_valid - winner/tie valid
//                sat_flag     - sticky counter saturation flag
//  Revision    : 1.0 - initial release
// ============================================================================
module vote_tally_engine
    import vote_pkg::*;
#(
    parameter int NUM_CAND    = 4,
    parameter int CNT_W       = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  mode,
    input  logic                                  ballot_arm,
    input  logic [NUM_CAND-1:0]                   button,
    input  logic [$clog2(NUM_CAND)-1:0]           disp_sel,
    output logic                                  armed,
    output logic                                  vote_ack,
    output logic                                  vote_reject,
    output logic [CNT_W-1:0]                      sel_count,
    output logic [CNT_W+$clog2(NUM_CAND)-1:0]     total_votes,
    output logic [$clog2(NUM_CAND)-1:0]           winner,
    output logic                                  tie,
    output logic                                  result_valid,
    output logic                                  sat_flag
);

    localparam int IDX_W = $clog2(NUM_CAND);
    localparam int TOT_W = CNT_W + IDX_W;

    generate
        if (NUM_CAND < NUM_CAND_MIN || NUM_CAND > NUM_CAND_MAX ||
            CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_param_check
            $error("vote_tally_engine: NUM_CAND or CNT_W out of range");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Button qualification
    // ------------------------------------------------------------------
    logic [NUM_CAND-1:0] pulses;

    generate
        for (genvar g = 0; g < NUM_CAND; g++) begin : g_qual
            vote_button_qualifier #(
                .HOLD_CYCLES (HOLD_CYCLES)
            ) u_qual (
                .clk       (clk),
                .rst_n     (rst_n),
                .button_in (button[g]),
                .pulse     (pulses[g])
            );
        end
    endgenerate

    // More than one bit set <=> clearing the lowest set bit leaves something.
    logic             multi_press;
    logic             any_press;
    logic [IDX_W-1:0] vote_idx;

    always_comb begin
        any_press   = |pulses;
        multi_press = |(pulses & (pulses - NUM_CAND'(1)));
        vote_idx    = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (pulses[i]) vote_idx = IDX_W'(i);
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    vote_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q [NUM_CAND];
    logic [CNT_W-1:0] cnt_d [NUM_CAND];
    logic [TOT_W-1:0] total_q, total_d;
    logic             sat_q, sat_d;
    logic             ack_q, ack_d;
    logic             rej_q, rej_d;
    logic             rv_q, rv_d;
    logic [IDX_W-1:0] winner_q, winner_d;
    logic             tie_q, tie_d;
    logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [IDX_W-1:0] best_q, best_d;
    logic             tie_run_q, tie_run_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        total_d    = total_q;
        sat_d      = sat_q;
        ack_d      = 1'b0;
        rej_d      = 1'b0;
        rv_d       = rv_q;
        winner_d   = winner_q;
        tie_d      = tie_q;
        scan_idx_d = scan_idx_q;
        max_d      = max_q;
        best_d     = best_q;
        tie_run_d  = tie_run_q;

        case (state_q)
            ST_LOCKED: begin
                if (mode == MODE_RESULT) begin
                    state_d    = ST_SCAN;
                    scan_idx_d = '0;
                end else if (ballot_arm) begin
                    state_d = ST_ARMED;
                end
            end

            ST_ARMED: begin
                // Entering result mode silently cancels the pending ballot.
                if (mode == MODE_RESULT) begin
                    state_d    = ST_SCAN;
                    scan_idx_d = '0;
                end else if (multi_press) begin
                    rej_d = 1'b1;
                end else if (any_press) begin
                    ack_d   = 1'b1;
                    state_d = ST_LOCKED;
                    if (cnt_q[vote_idx] == {CNT_W{1'b1}}) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d[vote_idx] = cnt_q[vote_idx] + CNT_W'(1);
                        total_d         = total_q + TOT_W'(1);
                    end
                end
            end

            ST_SCAN: begin
                if (mode == MODE_VOTE) begin
                    state_d = ST_LOCKED;
                    rv_d    = 1'b0;
                end else begin
                    // Strict '>' keeps the lowest index on equal counts.
                    if (scan_idx_q == '0) begin
                        max_d     = cnt_q[scan_idx_q];
                        best_d    = '0;
                        tie_run_d = 1'b0;
                    end else if (cnt_q[scan_idx_q] > max_q) begin
                        max_d     = cnt_q[scan_idx_q];
                        best_d    = scan_idx_q;
                        tie_run_d = 1'b0;
                    end else if (cnt_q[scan_idx_q] == max_q) begin
                        tie_run_d = 1'b1;
                    end

                    if (scan_idx_q == IDX_W'(NUM_CAND - 1)) begin
                        winner_d = best_d;
                        tie_d    = tie_run_d;
                        rv_d     = 1'b1;
                        state_d  = ST_RESULT;
                    end else begin
                        scan_idx_d = scan_idx_q + IDX_W'(1);
                    end
                end
            end

            ST_RESULT: begin
                if (mode == MODE_VOTE) begin
                    state_d = ST_LOCKED;
                    rv_d    = 1'b0;
                end
            end

            default: begin
                state_d = ST_LOCKED;
                rv_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LOCKED;
            for (int i = 0; i < NUM_CAND; i++) cnt_q[i] <= '0;
            total_q    <= '0;
            sat_q      <= 1'b0;
            ack_q      <= 1'b0;
            rej_q      <= 1'b0;
            rv_q       <= 1'b0;
            winner_q   <= '0;
            tie_q      <= 1'b0;
            scan_idx_q <= '0;
            max_q      <= '0;
            best_q     <= '0;
            tie_run_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            total_q    <= total_d;
            sat_q      <= sat_d;
            ack_q      <= ack_d;
            rej_q      <= rej_d;
            rv_q       <= rv_d;
            winner_q   <= winner_d;
            tie_q      <= tie_d;
            scan_idx_q <= scan_idx_d;
            max_q      <= max_d;
            best_q     <= best_d;
            tie_run_q  <= tie_run_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        sel_count = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (disp_sel == IDX_W'(i)) sel_count = cnt_q[i];
        end
    end

    assign armed        = (state_q == ST_ARMED);
    assign vote_ack     = ack_q;
    assign vote_reject  = rej_q;
    assign total_votes  = total_q;
    assign winner       = winner_q;
    assign tie          = tie_q;
    assign result_valid = rv_q;
    assign sat_flag     = sat_q;

endmodule : vote_tally_engine
`default_nettype wire

// File: tb/tb_vote_tally_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vote_tally_engine
//  Description : Self-checking bench for vote_tally_engine. Directed ballots
//                push expected ack/reject/result events into a scoreboard;
//                a monitor pops and compares when the DUT presents them.
//                A second instance (CNT_W=4) exercises counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vote_tally_engine;

    localparam int K_ACK = 0;
    localparam int K_REJ = 1;
    localparam int K_RES = 2;

    logic       clk;
    logic       rst_n;
    logic       mode, ballot_arm;
    logic [3:0] button;
    logic [1:0] disp_sel;
    logic       armed, vote_ack, vote_reject, tie, result_valid, sat_flag;
    logic [7:0] sel_count;
    logic [9:0] total_votes;
    logic [1:0] winner;

    logic       mode4, arm4;
    logic [3:0] button4;
    logic [1:0] disp_sel4;
    logic       armed4, ack4, rej4, tie4, rv4, sat4;
    logic [3:0] sel4;
    logic [5:0] total4;
    logic [1:0] winner4;

    vote_tally_engine #(.NUM_CAND(4), .CNT_W(8), .HOLD_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .ballot_arm(ballot_arm),
        .button(button), .disp_sel(disp_sel), .armed(armed),
        .vote_ack(vote_ack), .vote_reject(vote_reject), .sel_count(sel_count),
        .total_votes(total_votes), .winner(winner), .tie(tie),
        .result_valid(result_valid), .sat_flag(sat_flag)
    );

    vote_tally_engine #(.NUM_CAND(4), .CNT_W(4), .HOLD_CYCLES(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .mode(mode4), .ballot_arm(arm4),
        .button(button4), .disp_sel(disp_sel4), .armed(armed4),
        .vote_ack(ack4), .vote_reject(rej4), .sel_count(sel4),
        .total_votes(total4), .winner(winner4), .tie(tie4),
        .result_valid(rv4), .sat_flag(sat4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int val;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   exp_cnt[4];
    int   exp_total = 0;
    int   n_ack4 = 0;
    logic rv_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic sb_pop(input int kind, input int val, input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_%s: got event with value %0d, expected none", name, val);
        end else begin
            e = exp_q.pop_front();
            check({name, "_kind"}, kind, e.kind);
            check({name, "_value"}, val, e.val);
        end
    endtask

    // Monitor: compares every event the DUT presents against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            rv_prev = 1'b0;
        end else begin
            if (vote_ack)    sb_pop(K_ACK, int'(total_votes), "ack");
            if (vote_reject) sb_pop(K_REJ, int'(total_votes), "reject");
            if (result_valid && !rv_prev) sb_pop(K_RES, int'({winner, tie}), "result");
            rv_prev = result_valid;
        end
    end

    always @(negedge clk) begin
        if (rst_n && ack4) n_ack4++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input int val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic do_arm();
        ballot_arm = 1'b1;
        tick(1);
        ballot_arm = 1'b0;
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        button = mask;
        tick(hold);
        button = 4'b0000;
        tick(8);
    endtask

    task automatic vote(input int idx);
        do_arm();
        exp_total++;
        exp_cnt[idx]++;
        push(K_ACK, exp_total);
        press(4'b0001 << idx, 6);
    endtask

    task automatic chk_sel(input int idx, input int exp, input string name);
        disp_sel = idx[1:0];
        #1;
        check(name, sel_count, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int votes_tbl[11];
        votes_tbl = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 2, 3};
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;

        rst_n = 1'b0; mode = 1'b0; ballot_arm = 1'b0; button = '0; disp_sel = '0;
        mode4 = 1'b0; arm4 = 1'b0; button4 = '0; disp_sel4 = '0;
        tick(3);
        // Reset state
        check("rst_armed", armed, 0);
        check("rst_ack", vote_ack, 0);
        check("rst_reject", vote_reject, 0);
        check("rst_total", total_votes, 0);
        check("rst_winner", winner, 0);
        check("rst_tie", tie, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_sel_count", sel_count, 0);
        rst_n = 1'b1;
        tick(2);

        // Press without a ballot is ignored
        press(4'b0100, 10);
        check("noarm_total", total_votes, 0);
        chk_sel(2, 0, "noarm_count2");
        check("noarm_armed", armed, 0);

        // Arm, then a too-short press does not count
        do_arm();
        check("arm_armed", armed, 1);
        press(4'b0010, 3);
        check("short_armed", armed, 1);
        check("short_total", total_votes, 0);
        chk_sel(1, 0, "short_count1");

        // Long hold of button2 records exactly one vote
        exp_total = 1; exp_cnt[2] = 1;
        push(K_ACK, 1);
        press(4'b0100, 10);
        chk_sel(2, 1, "hold_count2");
        check("hold_total", total_votes, 1);
        check("hold_armed", armed, 0);

        // Two buttons together: reject, ballot stays pending
        do_arm();
        push(K_REJ, 1);
        press(4'b1001, 6);
        check("rej_armed", armed, 1);
        chk_sel(0, 0, "rej_count0");
        chk_sel(3, 0, "rej_count3");
        check("rej_total", total_votes, 1);
        exp_total = 2; exp_cnt[1] = 1;
        push(K_ACK, 2);
        press(4'b0010, 6);
        chk_sel(1, 1, "after_rej_count1");
        check("after_rej_armed", armed, 0);

        // Double arm gives one ballot only
        do_arm();
        do_arm();
        exp_total = 3; exp_cnt[1] = 2;
        push(K_ACK, 3);
        press(4'b0010, 6);
        check("dblarm_armed", armed, 0);
        press(4'b0010, 6);
        check("dblarm_total", total_votes, 3);
        chk_sel(1, 2, "dblarm_count1");

        // Bring counts to {3,5,5,1}
        for (int i = 0; i < 11; i++) vote(votes_tbl[i]);
        for (int i = 0; i < 4; i++) chk_sel(i, exp_cnt[i], "tally_count");
        check("tally_total", total_votes, 14);

        // Result scan: winner 1, tie, NUM_CAND+1 cycles latency
        push(K_RES, 3);
        mode = 1'b1;
        cyc = 0;
        while (!result_valid && cyc < 20) begin
            tick(1);
            cyc++;
        end
        check("result_latency", cyc, 5);
        check("result_armed", armed, 0);
        tick(2);
        mode = 1'b0;
        tick(1);
        check("mode_drop_rv", result_valid, 0);
        check("held_winner", winner, 1);
        check("held_tie", tie, 1);

        // Saturation on the narrow instance
        disp_sel4 = 2'd0;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("sat4_before", sat4, 0);
            arm4 = 1'b1;
            tick(1);
            arm4 = 1'b0;
            button4 = 4'b0001;
            tick(2);
            button4 = 4'b0000;
            tick(5);
        end
        check("sat4_acks", n_ack4, 16);
        check("sat4_count0", sel4, 15);
        check("sat4_flag", sat4, 1);
        check("sat4_total", total4, 15);

        // Pending ballot cancelled by mode, then reset mid-scan
        do_arm();
        check("pre_scan_armed", armed, 1);
        mode = 1'b1;
        tick(1);
        check("scan_cancel_armed", armed, 0);
        tick(1);
        rst_n = 1'b0;
        #1;
        check("midscan_rv", result_valid, 0);
        check("midscan_total", total_votes, 0);
        check("midscan_winner", winner, 0);
        check("midscan_tie", tie, 0);
        check("midscan_sat", sat_flag, 0);
        check("midscan_armed", armed, 0);
        for (int i = 0; i < 4; i++) chk_sel(i, 0, "midscan_count");
        mode = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("post_rst_rv", result_valid, 0);
        check("post_rst_armed", armed, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_vote_tally_engine
`default_nettype wire
